// File: rtl/regfile_pkg.sv
// Shared widths, register-index types and the hardwired-zero index for the
// 32x64 register file.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;

   localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/DECODER_E_5x32.sv
// Enabled 5-to-32 one-hot decoder: dec_o has exactly one bit set when en_i
// is high, and is all zeros otherwise.
module DECODER_E_5x32 (
   input  logic        en_i,
   input  logic [4:0]  addr_i,
   output logic [31:0] dec_o
);

   always_comb begin
      dec_o = '0;
      if (en_i) dec_o[addr_i] = 1'b1;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write vector for the register file: a mark sets a bit, a committed
// write clears it, and both busy lookups read the registered vector.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                mark_en_i,
   input  reg_addr_t           mark_addr_i,
   input  logic [NUM_REGS-1:0] clr_vec_i,
   input  reg_addr_t           rd_addr_a_i,
   input  reg_addr_t           rd_addr_b_i,
   output logic                busy_a_o,
   output logic                busy_b_o
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [NUM_REGS-1:0] mark_vec;

   // Set is applied after clear, so a new producer issued in the same cycle
   // as the old one's writeback keeps the register pending.
   always_comb begin
      mark_vec = '0;
      if (mark_en_i) mark_vec[mark_addr_i] = 1'b1;
      pending_d           = (pending_q & ~clr_vec_i) | mark_vec;
      pending_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) pending_q <= '0;
      else         pending_q <= pending_d;
   end

   assign busy_a_o = pending_q[rd_addr_a_i];
   assign busy_b_o = pending_q[rd_addr_b_i];

endmodule

// File: rtl/regfile_32x64.sv
// Two-read, one-write 32x64 register file with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_32x64
   import regfile_pkg::*;
(
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      wr_en_i,
   input  reg_addr_t wr_addr_i,
   input  reg_data_t wr_data_i,
   input  reg_addr_t rd_addr_a_i,
   output reg_data_t rd_data_a_o,
   output logic      rd_busy_a_o,
   input  reg_addr_t rd_addr_b_i,
   output reg_data_t rd_data_b_o,
   output logic      rd_busy_b_o,
   input  logic      mark_en_i,
   input  reg_addr_t mark_addr_i
);

   logic [NUM_REGS-1:0] wr_vec;
   reg_data_t           regs [NUM_REGS];
   logic                busy_a_q;
   logic                busy_b_q;

   DECODER_E_5x32 u_wr_dec (
      .en_i   (wr_en_i),
      .addr_i (wr_addr_i),
      .dec_o  (wr_vec)
   );

   regfile_scoreboard u_scoreboard (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .mark_en_i   (mark_en_i),
      .mark_addr_i (mark_addr_i),
      .clr_vec_i   (wr_vec),
      .rd_addr_a_i (rd_addr_a_i),
      .rd_addr_b_i (rd_addr_b_i),
      .busy_a_o    (busy_a_q),
      .busy_b_o    (busy_b_q)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_vec[i] && (reg_addr_t'(i) != ZERO_REG)) regs[i] <= wr_data_i;
         end
      end
   end

   // Forwarded reads leave busy asserted only when a newer producer is issued
   // against the same register in the same cycle.
   always_comb begin
      rd_data_a_o = (rd_addr_a_i == ZERO_REG) ? '0 : regs[rd_addr_a_i];
      rd_busy_a_o = busy_a_q;
      rd_data_b_o = (rd_addr_b_i == ZERO_REG) ? '0 : regs[rd_addr_b_i];
      rd_busy_b_o = busy_b_q;
`ifdef REGFILE_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_a_i) && (rd_addr_a_i != ZERO_REG)) begin
         rd_data_a_o = wr_data_i;
         if (!(mark_en_i && (mark_addr_i == rd_addr_a_i))) rd_busy_a_o = 1'b0;
      end
      if (wr_en_i && (wr_addr_i == rd_addr_b_i) && (rd_addr_b_i != ZERO_REG)) begin
         rd_data_b_o = wr_data_i;
         if (!(mark_en_i && (mark_addr_i == rd_addr_b_i))) rd_busy_b_o = 1'b0;
      end
`else
`endif
   end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed scenarios plus a randomized
// run against a reference model, all through an expected-value queue.
module tb_regfile_32x64;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wr_en_i;
   logic [4:0]  wr_addr_i;
   logic [63:0] wr_data_i;
   logic [4:0]  rd_addr_a_i;
   logic [63:0] rd_data_a_o;
   logic        rd_busy_a_o;
   logic [4:0]  rd_addr_b_i;
   logic [63:0] rd_data_b_o;
   logic        rd_busy_b_o;
   logic        mark_en_i;
   logic [4:0]  mark_addr_i;

   int checks = 0;
   int errors = 0;
   logic [64:0] exp_q[$];
   logic [64:0] exp;

   always #5 clk_i = ~clk_i;

   regfile_32x64 dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .rd_addr_a_i (rd_addr_a_i),
      .rd_data_a_o (rd_data_a_o),
      .rd_busy_a_o (rd_busy_a_o),
      .rd_addr_b_i (rd_addr_b_i),
      .rd_data_b_o (rd_data_b_o),
      .rd_busy_b_o (rd_busy_b_o),
      .mark_en_i   (mark_en_i),
      .mark_addr_i (mark_addr_i)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_idle();
      wr_en_i     = 1'b0;
      wr_addr_i   = '0;
      wr_data_i   = '0;
      mark_en_i   = 1'b0;
      mark_addr_i = '0;
   endtask

   task automatic drive_write(input logic [4:0] a, input logic [63:0] d);
      wr_en_i   = 1'b1;
      wr_addr_i = a;
      wr_data_i = d;
   endtask

   task automatic drive_mark(input logic [4:0] a);
      mark_en_i   = 1'b1;
      mark_addr_i = a;
   endtask

   task automatic test_reset();
      reset_i     = 1'b1;
      rd_addr_a_i = '0;
      rd_addr_b_i = '0;
      drive_idle();
      drive_write(5'd4, 64'hAAAA);
      drive_mark(5'd4);
      tick();
      tick();
      reset_i = 1'b0;
      drive_idle();
      for (int i = 0; i < 32; i++) begin
         rd_addr_a_i = 5'(i);
         rd_addr_b_i = 5'(31 - i);
         exp_q.push_back({1'b0, 64'h0});
         exp_q.push_back({1'b0, 64'h0});
         #1;
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
            errors++;
            $display("FAIL reset_a r%0d: got %h want %h", i, {rd_busy_a_o, rd_data_a_o}, exp);
         end
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
            errors++;
            $display("FAIL reset_b r%0d: got %h want %h", 31 - i, {rd_busy_b_o, rd_data_b_o}, exp);
         end
      end
   endtask

   task automatic test_write_read();
      drive_write(5'd5, 64'hDEAD_BEEF_0000_0001);
      tick();
      drive_idle();
      rd_addr_a_i = 5'd5;
      rd_addr_b_i = 5'd5;
      exp_q.push_back({1'b0, 64'hDEAD_BEEF_0000_0001});
      exp_q.push_back({1'b0, 64'hDEAD_BEEF_0000_0001});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL write_read_a: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
         errors++;
         $display("FAIL write_read_b: got %h want %h", {rd_busy_b_o, rd_data_b_o}, exp);
      end
      rd_addr_b_i = 5'd6;
      exp_q.push_back({1'b0, 64'h0});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
         errors++;
         $display("FAIL write_neighbour_r6: got %h want %h", {rd_busy_b_o, rd_data_b_o}, exp);
      end
   endtask

   task automatic test_zero_reg();
      drive_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      drive_mark(5'd31);
      rd_addr_a_i = 5'd31;
      rd_addr_b_i = 5'd31;
      exp_q.push_back({1'b0, 64'h0});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL zero_same_cycle_a: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
      tick();
      drive_idle();
      exp_q.push_back({1'b0, 64'h0});
      exp_q.push_back({1'b0, 64'h0});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL zero_reg_a: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
         errors++;
         $display("FAIL zero_reg_b: got %h want %h", {rd_busy_b_o, rd_data_b_o}, exp);
      end
   endtask

   task automatic test_mark();
      logic [64:0] steps [3] = '{{1'b1, 64'h0}, {1'b1, 64'h42}, {1'b0, 64'h43}};
      rd_addr_a_i = 5'd7;
      rd_addr_b_i = 5'd7;
      for (int s = 0; s < 3; s++) begin
         drive_idle();
         if (s == 0) drive_mark(5'd7);
         if (s == 1) begin drive_write(5'd7, 64'h42); drive_mark(5'd7); end
         if (s == 2) drive_write(5'd7, 64'h43);
         tick();
         drive_idle();
         exp_q.push_back(steps[s]);
         exp_q.push_back(steps[s]);
         #1;
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
            errors++;
            $display("FAIL mark_step%0d_a: got %h want %h", s, {rd_busy_a_o, rd_data_a_o}, exp);
         end
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
            errors++;
            $display("FAIL mark_step%0d_b: got %h want %h", s, {rd_busy_b_o, rd_data_b_o}, exp);
         end
      end
      // a double mark keeps the bit set
      drive_mark(5'd8);
      tick();
      tick();
      drive_idle();
      rd_addr_a_i = 5'd8;
      exp_q.push_back({1'b1, 64'h0});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL mark_twice_r8: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
   endtask

   task automatic test_bypass();
      drive_write(5'd9, 64'h55);
      tick();
      drive_write(5'd9, 64'h1234);
      rd_addr_a_i = 5'd9;
      rd_addr_b_i = 5'd9;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back({1'b0, 64'h1234});
      exp_q.push_back({1'b0, 64'h1234});
`else
      exp_q.push_back({1'b0, 64'h55});
      exp_q.push_back({1'b0, 64'h55});
`endif
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL bypass_a: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
         errors++;
         $display("FAIL bypass_b: got %h want %h", {rd_busy_b_o, rd_data_b_o}, exp);
      end
      tick();
      drive_idle();
      exp_q.push_back({1'b0, 64'h1234});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL bypass_after_a: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
   endtask

   task automatic test_reset_override();
      drive_write(5'd3, 64'h77);
      tick();
      drive_mark(5'd3);
      drive_write(5'd3, 64'h99);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      drive_idle();
      rd_addr_a_i = 5'd3;
      rd_addr_b_i = 5'd5;
      exp_q.push_back({1'b0, 64'h0});
      exp_q.push_back({1'b0, 64'h0});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
         errors++;
         $display("FAIL reset_override_r3: got %h want %h", {rd_busy_a_o, rd_data_a_o}, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
         errors++;
         $display("FAIL reset_override_r5: got %h want %h", {rd_busy_b_o, rd_data_b_o}, exp);
      end
   endtask

   function automatic logic [4:0] pick_addr();
      int p = $urandom_range(0, 8);
      return (p == 8) ? 5'd31 : 5'(p);
   endfunction

   function automatic logic [64:0] model_read(input logic [63:0] m_regs [32],
                                              input logic [31:0] m_pend,
                                              input logic [4:0]  a);
      logic [64:0] r;
      r = (a == 5'd31) ? 65'h0 : {m_pend[a], m_regs[a]};
`ifdef REGFILE_BYPASS_EN
      if (wr_en_i && (wr_addr_i == a) && (a != 5'd31)) begin
         r[63:0] = wr_data_i;
         if (!(mark_en_i && (mark_addr_i == a))) r[64] = 1'b0;
      end
`endif
      return r;
   endfunction

   task automatic test_back_to_back();
      logic [63:0] m_regs [32];
      logic [31:0] m_pend;
      reset_i = 1'b1;
      drive_idle();
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend = '0;
      for (int n = 0; n < 400; n++) begin
         wr_en_i     = ($urandom_range(0, 3) != 0);
         wr_addr_i   = pick_addr();
         wr_data_i   = {$urandom, $urandom};
         mark_en_i   = ($urandom_range(0, 2) == 0);
         mark_addr_i = pick_addr();
         rd_addr_a_i = pick_addr();
         rd_addr_b_i = pick_addr();
         exp_q.push_back(model_read(m_regs, m_pend, rd_addr_a_i));
         exp_q.push_back(model_read(m_regs, m_pend, rd_addr_b_i));
         #1;
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_a_o, rd_data_a_o} !== exp) begin
            errors++;
            $display("FAIL random_a n=%0d r%0d: got %h want %h", n, rd_addr_a_i, {rd_busy_a_o, rd_data_a_o}, exp);
         end
         exp = exp_q.pop_front(); checks++;
         if ({rd_busy_b_o, rd_data_b_o} !== exp) begin
            errors++;
            $display("FAIL random_b n=%0d r%0d: got %h want %h", n, rd_addr_b_i, {rd_busy_b_o, rd_data_b_o}, exp);
         end
         if (wr_en_i && (wr_addr_i != 5'd31)) begin
            m_regs[wr_addr_i] = wr_data_i;
            m_pend[wr_addr_i] = 1'b0;
         end
         if (mark_en_i && (mark_addr_i != 5'd31)) m_pend[mark_addr_i] = 1'b1;
         tick();
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_reg();
      test_mark();
      test_bypass();
      test_reset_override();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d leftover want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_32x64.md
# regfile_32x64

Two-read, one-write register file with an integrated pending-write scoreboard, consuming the one-hot write-enable vector from the 5x32 enabled write decoder. It holds the 32 architectural 64-bit registers of the CPU datapath. Register 31 is hardwired to zero. Decode reads operands and busy status combinationally. Writeback commits on the clock edge.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register address width; fixed at 5 because the write decoder is 5x32
- ZERO_REG, 31, index of the hardwired-zero register
- clk_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  writeback enable
- wr_addr_i  in  5  writeback register index
- wr_data_i  in  DATA_WIDTH  writeback data
- rd_addr_a_i  in  5  read port A index
- rd_data_a_o  out  DATA_WIDTH  read port A data
- rd_busy_a_o  out  1  port A register has a pending write
- rd_addr_b_i  in  5  read port B index
- rd_data_b_o  out  DATA_WIDTH  read port B data
- rd_busy_b_o  out  1  port B register has a pending write
- mark_en_i  in  1  issue marks a destination register as pending
- mark_addr_i  in  5  destination register to mark

## Operation
- Storage is 32 registers of DATA_WIDTH bits, plus a 32-bit pending vector.
- The write decoder produces the write-enable vector from wr_addr_i, with wr_en_i as its enable. Register i loads wr_data_i when bit i is set and i != ZERO_REG.
- Reads of ZERO_REG always return 0, and the matching busy output is always 0.
- Pending bit i sets when mark_en_i is high and mark_addr_i == i. It clears when a write to i commits.
- Mark and write to the same index in the same cycle: mark wins and the bit stays set, because a newer producer has been issued. The data is still written.
- Marks and writes to ZERO_REG are ignored. Pending bit 31 is constant 0.
- Marking an already-pending register is legal. The bit stays set.
- rd_busy_x_o is pending[rd_addr_x_i], taken from registered state.

## Timing
- Reset: all 32 registers are 0 and the pending vector is 0 on the first rising edge with reset_i high. Reset overrides any write or mark in that cycle.
- After reset, rd_data_a_o and rd_data_b_o read 0 and both busy outputs read 0.
- Reads are combinational from the address inputs, with zero-cycle latency.
- A write is visible on the read ports in the cycle after the edge that commits it.
- A pending bit set by a mark is visible on busy outputs one cycle after the mark edge. A clear is visible one cycle after the write edge.
- Both read ports may address the same register, including the one being written. They resolve independently.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding.
  - When wr_en_i is high, wr_addr_i == rd_addr_x_i and the address != ZERO_REG, rd_data_x_o = wr_data_i.
  - rd_busy_x_o is forced to 0 for that port, unless mark_en_i targets the same register in that cycle.
- REGFILE_BYPASS_EN undefined: the read returns the old register contents and the registered busy bit. There is no forwarding path.

## Structure
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, ZERO_REG and NUM_REGS = 32
  - typedef reg_addr_t (5 bits)
  - typedef reg_data_t (DATA_WIDTH bits)
- Write enables come from the existing DECODER_E_5x32, instantiated once.
- One new sub-module, regfile_scoreboard, owns the pending vector with its set/clear priority and the two busy lookups.

## Test plan
- Reset, then read all 32 addresses on both ports: every read returns 0 with busy 0.
- Write 0xDEAD_BEEF_0000_0001 to R5, then read R5 on A and B the next cycle: both return 0xDEAD_BEEF_0000_0001.
- Write 0xFFFF_FFFF_FFFF_FFFF to R31, then read R31: returns 0 with busy 0.
- Mark R7, next cycle read R7: busy 1.
  - Write R7 = 0x42 and mark R7 in the same cycle: next cycle busy 1, data 0x42.
  - Write R7 = 0x43 alone: next cycle busy 0, data 0x43.
- Same cycle, write R9 = 0x1234 and read R9 on port A:
  - With REGFILE_BYPASS_EN: returns 0x1234, busy 0.
  - Without: returns the old value.
- Mark R3 and write R3 = 0x99, with reset_i high that cycle: next cycle R3 reads 0, busy 0.
